ifetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS pipeline.
- Owns the program counter, drives the byte address into the combinational instruction memory bank, and captures the returned word into the IF/ID pipeline register.
- Accepts stall and redirect requests from the decode/hazard logic. Flags out-of-range or misaligned fetches and halts on them.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/pc_reg.sv | 51 +++++
 rtl/ifetch_stage.sv | 79 +++++++
 tb/tb_ifetch_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
package mips_pkg;

  // Default instruction memory depth in 32-bit words.
  localparam int IMEM_WORDS_DEF = 128;

  // Encoding of the canonical NOP (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default program counter after reset.
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // IF/ID pipeline register contents, also consumed by the decode stage.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  // Sequential next-instruction address; 32-bit modulo.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with halt/redirect/stall next-PC mux and bad-address check.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_q,
  output logic        bad
);

  // One bit wider than the PC so the byte limit never truncates.
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  logic [31:0] pc_next;

  // Misaligned or beyond the end of instruction memory.
  always_comb begin
    bad = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= IMEM_LIMIT);
  end

  // Next-PC selection; a halted stage never moves until reset.
  always_comb begin
    pc_next = pc_q;
    if (halt) begin
      pc_next = pc_q;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (stall || bad) begin
      pc_next = pc_q;
    end else begin
      pc_next = pc_plus4(pc_q);
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: drives the instruction memory address, captures
// the returned word into IF/ID, and halts on a bad fetch address.
module ifetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IMEM_WORDS = IMEM_WORDS_DEF,
  parameter logic [31:0] NOP_WORD   = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q;
  logic        bad;
  if_id_t      if_id_q;
  logic        fault_q;
  logic [31:0] count_q;

  pc_reg #(
    .RESET_PC  (RESET_PC),
    .IMEM_WORDS(IMEM_WORDS)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt          (fault_q),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc_q          (pc_q),
    .bad           (bad)
  );

  assign imem_addr   = pc_q;
  assign if_id_valid = if_id_q.valid;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

  // IF/ID capture, sticky fault and delivered-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q.valid <= 1'b0;
      if_id_q.instr <= NOP_WORD;
      if_id_q.pc4   <= 32'h0;
      fault_q       <= 1'b0;
      count_q       <= 32'h0;
    end else if (fault_q || redirect_valid) begin
      // Halted, or squashing the wrong-path word: insert a bubble, keep pc4.
      if_id_q.valid <= 1'b0;
      if_id_q.instr <= NOP_WORD;
    end else if (stall) begin
      // Hold everything for the hazard unit.
      if_id_q <= if_id_q;
    end else if (bad) begin
      // The memory word is meaningless here, so it is never captured.
      fault_q       <= 1'b1;
      if_id_q.valid <= 1'b0;
      if_id_q.instr <= NOP_WORD;
    end else begin
      if_id_q.valid <= 1'b1;
      if_id_q.instr <= imem_rdata;
      if_id_q.pc4   <= pc_plus4(pc_q);
      count_q       <= count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage.
module tb_ifetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:127];
  int          n_checks;
  int          n_pass;

  ifetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .fetch_fault   (fetch_fault),
    .fetch_count   (fetch_count)
  );

  // Combinational instruction memory.
  assign imem_rdata = mem[imem_addr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t addr=%h valid=%b instr=%h pc4=%h fault=%b count=%0d",
             $time, imem_addr, if_id_valid, if_id_instr, if_id_pc4, fetch_fault, fetch_count);
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic [31:0] cnt);
    check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"},   if_id_pc4, pc4);
    check({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 128; i++) mem[i] = {16'hA5A5, 16'(i)};
    mem[0] = 32'h0000_4020;
    mem[1] = 32'h2009_0007;

    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state, before any clock edge.
    #2;
    check("rst.addr", imem_addr, 32'h0);
    check("rst.fault", 32'(fetch_fault), 32'h0);
    check_ifid("rst", 1'b0, 32'h0, 32'h0, 32'd0);
    #10 rst_n = 1'b1;

    // First two fetches.
    step();
    check_ifid("f1", 1'b1, 32'h0000_4020, 32'd4, 32'd1);
    step();
    check_ifid("f2", 1'b1, 32'h2009_0007, 32'd8, 32'd2);
    check("f2.addr", imem_addr, 32'd8);

    // Three-cycle stall at pc 8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.addr", imem_addr, 32'd8);
      check_ifid("stall", 1'b1, 32'h2009_0007, 32'd8, 32'd2);
    end
    stall = 1'b0;
    step();
    check_ifid("resume", 1'b1, 32'hA5A5_0002, 32'd12, 32'd3);

    // Redirect wins over simultaneous stall.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h28;
    stall          = 1'b1;
    step();
    check_ifid("redir", 1'b0, 32'h0, 32'd12, 32'd3);
    check("redir.addr", imem_addr, 32'h28);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    step();
    check_ifid("tgt", 1'b1, 32'hA5A5_000A, 32'h2C, 32'd4);

    // Run off the end of memory.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1FC;
    step();
    check("last.bubble", 32'(if_id_valid), 32'h0);
    redirect_valid = 1'b0;
    step();
    check_ifid("last", 1'b1, 32'hA5A5_007F, 32'h200, 32'd5);
    check("last.fault", 32'(fetch_fault), 32'h0);
    step();
    check("oor.fault", 32'(fetch_fault), 32'h1);
    check_ifid("oor", 1'b0, 32'h0, 32'h200, 32'd5);
    check("oor.addr", imem_addr, 32'h200);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    check("halt.addr", imem_addr, 32'h200);
    check("halt.fault", 32'(fetch_fault), 32'h1);
    check_ifid("halt", 1'b0, 32'h0, 32'h200, 32'd5);
    redirect_valid = 1'b0;

    // Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    check("arst.addr", imem_addr, 32'h0);
    check("arst.fault", 32'(fetch_fault), 32'h0);
    check_ifid("arst", 1'b0, 32'h0, 32'h0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_ifid("restart", 1'b1, 32'h0000_4020, 32'd4, 32'd1);

    // Misaligned redirect: fault comes on the next unstalled edge.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    step();
    check("mis.redir.fault", 32'(fetch_fault), 32'h0);
    check("mis.addr", imem_addr, 32'h6);
    redirect_valid = 1'b0;
    stall          = 1'b1;
    step();
    check("mis.stall.fault", 32'(fetch_fault), 32'h0);
    stall = 1'b0;
    step();
    check("mis.fault", 32'(fetch_fault), 32'h1);
    check_ifid("mis", 1'b0, 32'h0, 32'd4, 32'd1);
    check("mis.hold", imem_addr, 32'h6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
